// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIF FFT.
// Issues one butterfly per cycle, drains the butterfly pipeline between
// stages and aligns write-back addresses with the butterfly output register.
module fft_stage_sequencer #(
    parameter int N = 64,
    localparam int LOG2N = $clog2(N),
    localparam int SW = $clog2(LOG2N) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SW-1:0]      stage,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_idx,
    output logic               bf_enable,
    output logic               wr_en,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [LOG2N-1:0] A_ONE  = LOG2N'(1);
    localparam logic [LOG2N-2:0] K_ONE  = (LOG2N-1)'(1);
    localparam logic [LOG2N-2:0] K_LAST = '1;
    localparam logic [SW-1:0]    S_ONE  = SW'(1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);

    state_t             state;
    logic [LOG2N-2:0]   k;
    logic               drain_cnt;
    logic               wr_en_p1;
    logic [LOG2N-1:0]   wr_addr_a_p1;
    logic [LOG2N-1:0]   wr_addr_b_p1;

    // Mask of the address bits below the butterfly span bit (span = N >> (s+1)).
    function automatic logic [LOG2N-1:0] low_mask(input logic [SW-1:0] ss);
        return (A_ONE << (LOG2N - 1 - int'(ss))) - A_ONE;
    endfunction

    // Operand A: butterfly index k with a zero inserted at the span bit,
    // i.e. g*2*span + j without any division.
    function automatic logic [LOG2N-1:0] addr_a_of(input logic [LOG2N-2:0] kk,
                                                   input logic [SW-1:0]    ss);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] m;
        kx = {1'b0, kk};
        m  = low_mask(ss);
        return ((kx & ~m) << 1) | (kx & m);
    endfunction

    // Operand B sits exactly one span above operand A.
    function automatic logic [LOG2N-1:0] addr_b_of(input logic [LOG2N-2:0] kk,
                                                   input logic [SW-1:0]    ss);
        return addr_a_of(kk, ss) | (low_mask(ss) + A_ONE);
    endfunction

    // Twiddle index j << s; always below N/2 so the top bit is dropped.
    function automatic logic [LOG2N-2:0] tw_of(input logic [LOG2N-2:0] kk,
                                               input logic [SW-1:0]    ss);
        logic [LOG2N-1:0] t;
        t = ({1'b0, kk} & low_mask(ss)) << ss;
        return t[LOG2N-2:0];
    endfunction

    // Stage/butterfly sequencing FSM with registered read-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= 1'b0;
            stage     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        stage     <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr_a <= addr_a_of('0, '0);
                        rd_addr_b <= addr_b_of('0, '0);
                        tw_idx    <= tw_of('0, '0);
                    end
                end
                ISSUE: begin
                    if (k == K_LAST) begin
                        state     <= DRAIN;
                        k         <= '0;
                        drain_cnt <= 1'b0;
                        rd_en     <= 1'b0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        tw_idx    <= '0;
                    end else begin
                        k         <= k + K_ONE;
                        rd_addr_a <= addr_a_of(k + K_ONE, stage);
                        rd_addr_b <= addr_b_of(k + K_ONE, stage);
                        tw_idx    <= tw_of(k + K_ONE, stage);
                    end
                end
                DRAIN: begin
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                    end else if (stage == S_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ISSUE;
                        stage     <= stage + S_ONE;
                        rd_en     <= 1'b1;
                        rd_addr_a <= addr_a_of('0, stage + S_ONE);
                        rd_addr_b <= addr_b_of('0, stage + S_ONE);
                        tw_idx    <= tw_of('0, stage + S_ONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    stage <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay line: memory read (1 cycle) then butterfly output register (1 cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            bf_enable    <= 1'b0;
            wr_en_p1     <= 1'b0;
            wr_addr_a_p1 <= '0;
            wr_addr_b_p1 <= '0;
            wr_en        <= 1'b0;
            wr_addr_a    <= '0;
            wr_addr_b    <= '0;
        end else begin
            bf_enable    <= rd_en;
            wr_en_p1     <= rd_en;
            wr_addr_a_p1 <= rd_addr_a;
            wr_addr_b_p1 <= rd_addr_b;
            wr_en        <= wr_en_p1;
            wr_addr_a    <= wr_addr_a_p1;
            wr_addr_b    <= wr_addr_b_p1;
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: N=8 cycle-exact scoreboard and an N=64
// impulse run through a butterfly + memory model.
module tb_fft_stage_sequencer;

    typedef struct {
        int rd, a, b, tw, bf, wr, wa, wb, busy, done, stg;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start8, start64;

    logic       busy8, done8, rd_en8, bf8, wr8;
    logic [2:0] stage8;
    logic [2:0] ra8, rb8, wa8, wb8;
    logic [1:0] tw8;

    logic       busy64, done64, rd_en64, bf64, wr64;
    logic [3:0] stage64;
    logic [5:0] ra64, rb64, wa64, wb64;
    logic [4:0] tw64;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    int cnt [0:5][0:63];

    real mem_re [0:63];
    real mem_im [0:63];
    real ar, ai, br, bi, xr, xi, yr, yi;
    int  tw_r;
    localparam real W_STEP = 2.0 * 3.14159265358979 / 64.0;

    fft_stage_sequencer #(.N(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
        .stage(stage8), .rd_en(rd_en8), .rd_addr_a(ra8), .rd_addr_b(rb8),
        .tw_idx(tw8), .bf_enable(bf8), .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8)
    );

    fft_stage_sequencer #(.N(64)) u64 (
        .clk(clk), .reset(reset), .start(start64), .busy(busy64), .done(done64),
        .stage(stage64), .rd_en(rd_en64), .rd_addr_a(ra64), .rd_addr_b(rb64),
        .tw_idx(tw64), .bf_enable(bf64), .wr_en(wr64), .wr_addr_a(wa64), .wr_addr_b(wb64)
    );

    always #5 clk = ~clk;

    // Memory (1-cycle read), twiddle ROM and butterfly register for the N=64 DUT.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem_re[i] <= (i == 0) ? 1.0 : 0.0;
                mem_im[i] <= 0.0;
            end
        end else begin
            if (rd_en64) begin
                ar   <= mem_re[ra64];
                ai   <= mem_im[ra64];
                br   <= mem_re[rb64];
                bi   <= mem_im[rb64];
                tw_r <= int'(tw64);
            end
            if (bf64) begin
                xr <= ar + br;
                xi <= ai + bi;
                yr <= (ar - br) * $cos(W_STEP * real'(tw_r)) + (ai - bi) * $sin(W_STEP * real'(tw_r));
                yi <= (ai - bi) * $cos(W_STEP * real'(tw_r)) - (ar - br) * $sin(W_STEP * real'(tw_r));
            end
            if (wr64) begin
                mem_re[wa64] <= xr;
                mem_im[wa64] <= xi;
                mem_re[wb64] <= yr;
                mem_im[wb64] <= yi;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Read side of an N=8 transform, rel = cycles after start was sampled.
    function automatic exp_t base8(input int rel);
        exp_t e;
        int st, ph, span;
        e = '{default: 0};
        e.stg = -1;
        if (rel >= 1 && rel <= 18) begin
            st = (rel - 1) / 6;
            ph = (rel - 1) % 6;
            e.stg = st;
            if (ph < 4) begin
                span = 8 >> (st + 1);
                e.rd = 1;
                e.a  = (ph / span) * 2 * span + (ph % span);
                e.b  = e.a + span;
                e.tw = (ph % span) << st;
            end
        end
        return e;
    endfunction

    function automatic exp_t model8(input int rel);
        exp_t e, p1, p2;
        e  = base8(rel);
        p1 = base8(rel - 1);
        p2 = base8(rel - 2);
        e.bf   = p1.rd;
        e.wr   = p2.rd;
        e.wa   = p2.a;
        e.wb   = p2.b;
        e.busy = (rel >= 1 && rel <= 19) ? 1 : 0;
        e.done = (rel == 19) ? 1 : 0;
        return e;
    endfunction

    task automatic push_run(input int upto);
        for (int r = 1; r <= upto; r++) sb.push_back(model8(r));
    endtask

    task automatic push_zero(input int n);
        exp_t z;
        z = '{default: 0};
        for (int i = 0; i < n; i++) sb.push_back(z);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int rel;
        int bad;
        reset   = 1'b1;
        start8  = 1'b0;
        start64 = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("rd_en", int'(rd_en8), mon_e.rd);
                    chk("rd_addr_a", int'(ra8), mon_e.a);
                    chk("rd_addr_b", int'(rb8), mon_e.b);
                    chk("tw_idx", int'(tw8), mon_e.tw);
                    chk("bf_enable", int'(bf8), mon_e.bf);
                    chk("wr_en", int'(wr8), mon_e.wr);
                    chk("wr_addr_a", int'(wa8), mon_e.wa);
                    chk("wr_addr_b", int'(wb8), mon_e.wb);
                    chk("busy", int'(busy8), mon_e.busy);
                    chk("done", int'(done8), mon_e.done);
                    if (mon_e.stg >= 0) chk("stage", int'(stage8), mon_e.stg);
                end
                if (!reset && rd_en64 && stage64 < 4'd6) begin
                    cnt[stage64][ra64] += 1;
                    cnt[stage64][rb64] += 1;
                end
            end
        join_none

        // Reset state
        step();
        step();
        push_zero(2);
        step();
        step();
        reset = 1'b0;
        step();

        // Single N=8 transform
        start8 = 1'b1;
        push_run(20);
        step();
        start8 = 1'b0;
        drain();

        // start held high: two back-to-back transforms, start ignored while busy
        start8 = 1'b1;
        push_run(20);
        push_run(20);
        repeat (30) step();
        start8 = 1'b0;
        drain();

        // Reset at cycle 8 aborts the transform, no write-back of pending reads
        start8 = 1'b1;
        push_run(8);
        push_zero(3);
        step();
        start8 = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drain();

        // Restart after abort completes normally
        start8 = 1'b1;
        push_run(20);
        step();
        start8 = 1'b0;
        drain();

        // N=64 impulse transform
        rel = -1;
        start64 = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 1) start64 = 1'b0;
            if (done64) begin
                rel = i;
                break;
            end
        end
        chk("done64_cycle", rel, 205);
        step();
        chk("busy64_after_done", int'(busy64), 0);
        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int a = 0; a < 64; a++) if (cnt[s][a] != 1) bad++;
            chk($sformatf("perm_stage%0d", s), bad, 0);
        end
        for (int a = 0; a < 64; a++) begin
            chk($sformatf("bin%0d_re_x1000", a), int'(mem_re[a] * 1000.0), 1000);
            chk($sformatf("bin%0d_im_x1000", a), int'(mem_im[a] * 1000.0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Controller that sequences the radix-2 DIF butterfly through a complete in-place N-point FFT held in a dual-port sample memory.
- Generates per-cycle read addresses for the A/B operand pair and the twiddle ROM index.
- Drives the butterfly enable.
- Issues write-back addresses aligned to the butterfly's 1-cycle output register.
- Steps through all log2(N) stages, inserts a pipeline drain between stages, and signals completion. Output data is left in bit-reversed order.

Parameters:
- N, 64, FFT size. Power of two, >= 4.
- LOG2N, $clog2(N), localparam. Number of stages and address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin transform; sampled only in IDLE
- busy  output  1  high from cycle after start accepted through DONE cycle inclusive
- done  output  1  single-cycle pulse when last write-back has been issued
- stage  output  $clog2(LOG2N)+1  current stage index s, 0..LOG2N-1
- rd_en  output  1  memory read strobe (synchronous read, 1-cycle latency)
- rd_addr_a  output  LOG2N  address of operand A
- rd_addr_b  output  LOG2N  address of operand B
- tw_idx  output  LOG2N-1  twiddle ROM index (synchronous, 1-cycle latency, same timing as memory)
- bf_enable  output  1  butterfly enable
- wr_en  output  1  write-back strobe for X->addr_a, Y->addr_b
- wr_addr_a  output  LOG2N  write address for butterfly X
- wr_addr_b  output  LOG2N  write address for butterfly Y

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 -> ISSUE with s=0, k=0.
  - start ignored in all other states; no queuing.
- ISSUE, one butterfly per cycle, k = 0..N/2-1:
  - span = N >> (s+1); j = k mod span; g = k / span.
  - rd_addr_a = g*2*span + j; rd_addr_b = rd_addr_a + span; tw_idx = j << s; rd_en=1.
  - Shift/mask arithmetic only, no dividers.
  - When k = N/2-1 -> DRAIN, k cleared.
- DRAIN, exactly 2 cycles, rd_en=0. Guarantees the last write of stage s lands before stage s+1 reads.
  - After the 2nd cycle: if s < LOG2N-1, then s++ and -> ISSUE.
  - Otherwise -> DONE.
- DONE, 1 cycle: done=1 -> IDLE. busy drops the cycle after DONE.
- Pipeline alignment:
  - bf_enable = rd_en delayed 1 cycle.
  - wr_en, wr_addr_a and wr_addr_b = rd_en, rd_addr_a and rd_addr_b delayed 2 cycles.
  - Twiddle data is valid in the same cycle as the operands.
- Outputs when rd_en=0: rd_addr_a, rd_addr_b and tw_idx hold 0. Delayed copies follow the same rule.
- Latency: start sampled at cycle 0; first rd_en at cycle 1; per stage N/2+2 cycles; done at cycle 1 + LOG2N*(N/2+2).
  - N=64: done at cycle 205.
  - N=8: done at cycle 19.
- Reset:
  - FSM -> IDLE; s, k, and all delay registers cleared.
  - All outputs 0, including busy, done, rd_en, bf_enable, wr_en, addresses, tw_idx and stage.
  - Reset mid-transform discards in-flight writes: wr_en must be 0 the cycle after reset, even if reads were pending.
- Simultaneous events:
  - start asserted in the DONE cycle is ignored.
  - A new start is accepted only from IDLE, so the earliest restart is the cycle after DONE.

Test Plan:
- N=8, start pulse at cycle 0 -> stage 0 rd pairs (0,4),(1,5),(2,6),(3,7) with tw_idx 0,1,2,3 on cycles 1-4; wr_en on cycles 3-6 with same pairs; bf_enable on cycles 2-5.
- N=8 stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), tw_idx 0,2,0,2 on cycles 7-10. Stage 2 -> pairs (0,1),(2,3),(4,5),(6,7), tw_idx 0 on cycles 13-16. done=1 only at cycle 19. busy high cycles 1-19.
- Drain check, N=8 -> rd_en=0 on cycles 5-6 and 11-12. Last wr_en of each stage precedes the next stage's first rd_en by exactly 1 cycle.
- start held high continuously -> back-to-back transforms, each 19 cycles, with one IDLE cycle between DONE and the next first rd_en. start pulses during busy are ignored.
- Reset asserted at cycle 8 of an N=8 run -> cycle 9: all outputs 0, state IDLE. wr_en never rises from the aborted reads. A new start completes normally.
- N=64 full run with a butterfly + memory model fed an impulse at x[0] -> all 64 bins equal, done at cycle 205. Read addresses within a stage are a permutation covering 0..63 exactly once.
